// File: rtl/xadc_drp_scheduler.sv
// xadc_drp_scheduler
//
// Single owner of the XADC dynamic reconfiguration port. Two requesters share it:
//   - an EOC-driven poller that reads die temperature, VCCINT and VCCAUX in turn.
//   - a host register-access port. The host wins when both are waiting.
// The latest 12-bit code of each status channel is held for the telemetry path.
//
// Optional build macro: XADC_SCHED_OVERTEMP_EN adds the overtemp_p output. It is
// set at a temperature code >= 12'hB5F and cleared below 12'hB0D. Between the two
// thresholds it holds its value.
//
// Ports:
//   clk210_p                 system clock, also the XADC dclk
//   reset_n_p                asynchronous active-low reset
//   eoc_p                    XADC end-of-conversion pulse, requests one poll
//   drp_do_p/drp_drdy_p      DRP read data and data-ready
//   drp_daddr_p/drp_den_p/drp_dwe_p/drp_di_p
//                            DRP address, enable pulse, write enable, write data
//   host_req_p               host request level, held until host_ack_p
//   host_we_p/host_addr_p/host_wdata_p
//                            host direction, address and write data
//   host_ack_p/host_err_p/host_rdata_p
//                            completion pulse, timeout flag, read data
//   temp_p/vccint_p/vccaux_p latest status codes, {4'd0, do[15:4]}
//   upd_p                    one-cycle pulse on any status register update
//   timeout_cnt_p            saturating count of DRP timeouts
//   busy_p                   a transaction is in progress
module xadc_drp_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [6:0]  TEMP_ADDR      = 7'h00,
  parameter logic [6:0]  VCCINT_ADDR    = 7'h01,
  parameter logic [6:0]  VCCAUX_ADDR    = 7'h02
) (
  input  logic        clk210_p,
  input  logic        reset_n_p,
  input  logic        eoc_p,
  input  logic [15:0] drp_do_p,
  input  logic        drp_drdy_p,
  output logic [6:0]  drp_daddr_p,
  output logic        drp_den_p,
  output logic        drp_dwe_p,
  output logic [15:0] drp_di_p,
  input  logic        host_req_p,
  input  logic        host_we_p,
  input  logic [6:0]  host_addr_p,
  input  logic [15:0] host_wdata_p,
  output logic        host_ack_p,
  output logic        host_err_p,
  output logic [15:0] host_rdata_p,
  output logic [15:0] temp_p,
  output logic [15:0] vccint_p,
  output logic [15:0] vccaux_p,
  output logic        upd_p,
  output logic [7:0]  timeout_cnt_p,
  output logic        busy_p
`ifdef XADC_SCHED_OVERTEMP_EN
  ,
  output logic        overtemp_p
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // The last WAIT cycle that can still accept drdy.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic       host_owner;
  logic       host_write;
  logic [1:0] slot;
  logic       pending;
  logic [7:0] timer;
  logic       start_host;
  logic       start_poll;

  assign start_host = (state == IDLE) && host_req_p;
  assign start_poll = (state == IDLE) && !host_req_p && pending;
  assign busy_p     = (state != IDLE);

  function automatic logic [6:0] slot_addr(input logic [1:0] s);
    case (s)
      2'd0:    slot_addr = TEMP_ADDR;
      2'd1:    slot_addr = VCCINT_ADDR;
      default: slot_addr = VCCAUX_ADDR;
    endcase
  endfunction

  // XADC status registers are MSB-justified 12-bit codes.
  function automatic logic [15:0] status_code(input logic [15:0] d);
    status_code = {4'd0, d[15:4]};
  endfunction

`ifdef XADC_SCHED_OVERTEMP_EN
  localparam logic [11:0] OT_SET = 12'hB5F;
  localparam logic [11:0] OT_CLR = 12'hB0D;

  function automatic logic next_overtemp(input logic [11:0] code, input logic cur);
    if (code >= OT_SET)
      next_overtemp = 1'b1;
    else if (code < OT_CLR)
      next_overtemp = 1'b0;
    else
      next_overtemp = cur;
  endfunction
`endif

  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      state         <= IDLE;
      host_owner    <= 1'b0;
      host_write    <= 1'b0;
      slot          <= 2'd0;
      pending       <= 1'b0;
      timer         <= 8'd0;
      drp_daddr_p   <= 7'd0;
      drp_den_p     <= 1'b0;
      drp_dwe_p     <= 1'b0;
      drp_di_p      <= 16'd0;
      host_ack_p    <= 1'b0;
      host_err_p    <= 1'b0;
      host_rdata_p  <= 16'd0;
      temp_p        <= 16'd0;
      vccint_p      <= 16'd0;
      vccaux_p      <= 16'd0;
      upd_p         <= 1'b0;
      timeout_cnt_p <= 8'd0;
`ifdef XADC_SCHED_OVERTEMP_EN
      overtemp_p    <= 1'b0;
`endif
    end else begin
      drp_den_p  <= 1'b0;
      drp_dwe_p  <= 1'b0;
      host_ack_p <= 1'b0;
      host_err_p <= 1'b0;
      upd_p      <= 1'b0;

      // An EOC arriving on the issue cycle must not be lost, so set wins over clear.
      if (eoc_p)
        pending <= 1'b1;
      else if (start_poll)
        pending <= 1'b0;

      case (state)
        IDLE: begin
          // The DRP outputs double as the latched transaction. They hold between transactions.
          if (start_host) begin
            host_owner  <= 1'b1;
            host_write  <= host_we_p;
            drp_daddr_p <= host_addr_p;
            drp_di_p    <= host_wdata_p;
            drp_dwe_p   <= host_we_p;
            drp_den_p   <= 1'b1;
            state       <= ISSUE;
          end else if (start_poll) begin
            host_owner  <= 1'b0;
            host_write  <= 1'b0;
            drp_daddr_p <= slot_addr(slot);
            drp_den_p   <= 1'b1;
            state       <= ISSUE;
          end
        end

        ISSUE: begin
          state <= WAIT;
          timer <= 8'd0;
        end

        WAIT: begin
          if (drp_drdy_p) begin
            state <= IDLE;
            if (host_owner) begin
              host_ack_p <= 1'b1;
              if (!host_write)
                host_rdata_p <= drp_do_p;
            end else begin
              upd_p <= 1'b1;
              case (slot)
                2'd0: begin
                  temp_p <= status_code(drp_do_p);
`ifdef XADC_SCHED_OVERTEMP_EN
                  overtemp_p <= next_overtemp(drp_do_p[15:4], overtemp_p);
`endif
                end
                2'd1:    vccint_p <= status_code(drp_do_p);
                default: vccaux_p <= status_code(drp_do_p);
              endcase
              slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
            end
          end else if (timer == TIMER_LAST) begin
            // Abort. A failed poll keeps its slot and waits for the next EOC.
            state <= IDLE;
            if (timeout_cnt_p != 8'hFF)
              timeout_cnt_p <= timeout_cnt_p + 8'd1;
            if (host_owner) begin
              host_ack_p <= 1'b1;
              host_err_p <= 1'b1;
            end
          end else begin
            timer <= timer + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Testbench for xadc_drp_scheduler.
// A DRP responder answers each den after a programmed latency, or never answers.
// A behavioural model predicts each transaction, host completion and status update.
// Monitors pop the predictions and compare them when the DUT presents den, ack or upd.
module tb_xadc_drp_scheduler;

  localparam int         TO     = 64;
  localparam logic [6:0] A_TEMP = 7'h00;
  localparam logic [6:0] A_VI   = 7'h01;
  localparam logic [6:0] A_VA   = 7'h02;

  logic        clk210_p     = 1'b0;
  logic        reset_n_p    = 1'b0;
  logic        eoc_p        = 1'b0;
  logic [15:0] drp_do_p     = 16'd0;
  logic        drp_drdy_p   = 1'b0;
  logic [6:0]  drp_daddr_p;
  logic        drp_den_p;
  logic        drp_dwe_p;
  logic [15:0] drp_di_p;
  logic        host_req_p   = 1'b0;
  logic        host_we_p    = 1'b0;
  logic [6:0]  host_addr_p  = 7'd0;
  logic [15:0] host_wdata_p = 16'd0;
  logic        host_ack_p;
  logic        host_err_p;
  logic [15:0] host_rdata_p;
  logic [15:0] temp_p;
  logic [15:0] vccint_p;
  logic [15:0] vccaux_p;
  logic        upd_p;
  logic [7:0]  timeout_cnt_p;
  logic        busy_p;
`ifdef XADC_SCHED_OVERTEMP_EN
  logic        overtemp_p;
`endif

  xadc_drp_scheduler #(
    .TIMEOUT_CYCLES(TO),
    .TEMP_ADDR     (A_TEMP),
    .VCCINT_ADDR   (A_VI),
    .VCCAUX_ADDR   (A_VA)
  ) dut (
    .clk210_p     (clk210_p),
    .reset_n_p    (reset_n_p),
    .eoc_p        (eoc_p),
    .drp_do_p     (drp_do_p),
    .drp_drdy_p   (drp_drdy_p),
    .drp_daddr_p  (drp_daddr_p),
    .drp_den_p    (drp_den_p),
    .drp_dwe_p    (drp_dwe_p),
    .drp_di_p     (drp_di_p),
    .host_req_p   (host_req_p),
    .host_we_p    (host_we_p),
    .host_addr_p  (host_addr_p),
    .host_wdata_p (host_wdata_p),
    .host_ack_p   (host_ack_p),
    .host_err_p   (host_err_p),
    .host_rdata_p (host_rdata_p),
    .temp_p       (temp_p),
    .vccint_p     (vccint_p),
    .vccaux_p     (vccaux_p),
    .upd_p        (upd_p),
    .timeout_cnt_p(timeout_cnt_p),
    .busy_p       (busy_p)
`ifdef XADC_SCHED_OVERTEMP_EN
    ,
    .overtemp_p   (overtemp_p)
`endif
  );

  initial forever #5 clk210_p = ~clk210_p;

  typedef struct packed {
    logic [6:0]  addr;
    logic        we;
    logic [15:0] di;
    logic        chk_di;
  } iss_t;

  typedef struct packed {
    int          lat;
    logic [15:0] data;
  } rsp_t;

  typedef struct packed {
    logic        err;
    logic [15:0] rdata;
  } hst_t;

  typedef struct packed {
    logic [15:0] t;
    logic [15:0] vi;
    logic [15:0] va;
    logic        ot;
  } upd_t;

  iss_t exp_iss[$];
  rsp_t rsp_q[$];
  hst_t exp_hst[$];
  upd_t exp_upd[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_den_cyc = 0;
  int last_ack_cyc = 0;
  int n_timeouts   = 0;

  // Reference model state
  int          slot_m;
  int          tcnt_m;
  logic [15:0] temp_m, vi_m, va_m, rdata_m;
  logic        ot_m;

  initial forever begin
    @(posedge clk210_p);
    cyc++;
  end

  initial begin
    repeat (95000) @(posedge clk210_p);
    $display("FAIL watchdog: run did not finish, got cycle %0d, limit 95000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit resp_ok(input int lat);
    return (lat >= 1) && (lat <= TO);
  endfunction

  function automatic int ack_lat(input int lat);
    return resp_ok(lat) ? lat + 1 : TO + 1;
  endfunction

  task automatic model_reset();
    slot_m = 0; tcnt_m = 0;
    temp_m = 16'd0; vi_m = 16'd0; va_m = 16'd0; rdata_m = 16'd0; ot_m = 1'b0;
  endtask

  task automatic bump_timeout();
    n_timeouts++;
    if (tcnt_m < 255) tcnt_m++;
  endtask

  task automatic poll_expect(input int lat, input logic [15:0] data);
    iss_t e; rsp_t r; upd_t u;
    logic [6:0] tab [3];
    logic [11:0] code;
    tab[0] = A_TEMP; tab[1] = A_VI; tab[2] = A_VA;
    e.addr = tab[slot_m]; e.we = 1'b0; e.di = 16'd0; e.chk_di = 1'b0;
    exp_iss.push_back(e);
    r.lat = lat; r.data = data;
    rsp_q.push_back(r);
    if (resp_ok(lat)) begin
      code = data[15:4];
      if (slot_m == 0) begin
        temp_m = {4'd0, code};
        if (code >= 12'hB5F) ot_m = 1'b1;
        else if (code < 12'hB0D) ot_m = 1'b0;
      end else if (slot_m == 1) vi_m = {4'd0, code};
      else va_m = {4'd0, code};
      slot_m = (slot_m + 1) % 3;
      u.t = temp_m; u.vi = vi_m; u.va = va_m; u.ot = ot_m;
      exp_upd.push_back(u);
    end else begin
      bump_timeout();
    end
  endtask

  task automatic host_expect(input logic we, input logic [6:0] addr, input logic [15:0] wdata,
                             input int lat, input logic [15:0] data, input bit acked);
    iss_t e; rsp_t r; hst_t h;
    e.addr = addr; e.we = we; e.di = wdata; e.chk_di = we;
    exp_iss.push_back(e);
    r.lat = lat; r.data = data;
    rsp_q.push_back(r);
    if (acked) begin
      if (resp_ok(lat)) begin
        if (!we) rdata_m = data;
        h.err = 1'b0;
      end else begin
        h.err = 1'b1;
        bump_timeout();
      end
      h.rdata = rdata_m;
      exp_hst.push_back(h);
    end
  endtask

  // Called at a falling edge. Holds the request until ack and drops it in the ack cycle.
  task automatic host_drive(input logic we, input logic [6:0] addr, input logic [15:0] wdata,
                            input int exp_ack);
    int req_c, n;
    host_we_p = we; host_addr_p = addr; host_wdata_p = wdata; host_req_p = 1'b1;
    req_c = cyc; n = 0;
    do begin
      @(negedge clk210_p);
      n++;
    end while (!host_ack_p && n < 300);
    host_req_p = 1'b0;
    if (!host_ack_p) begin
      check("host_ack_wait", host_ack_p, 1);
    end else begin
      last_ack_cyc = cyc;
      check("host_den_latency", last_den_cyc - req_c, 1);
      check("host_ack_latency", cyc - last_den_cyc, exp_ack);
    end
  endtask

  task automatic eoc_pulse();
    @(negedge clk210_p);
    eoc_p = 1'b1;
    @(negedge clk210_p);
    eoc_p = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    repeat (3) @(negedge clk210_p);
    n = 0;
    while (busy_p && n < 300) begin
      @(negedge clk210_p);
      n++;
    end
    if (busy_p) check("idle_wait", busy_p, 0);
    @(negedge clk210_p);
  endtask

  task automatic check_state();
    check("timeout_cnt", timeout_cnt_p, tcnt_m);
    check("temp", temp_p, temp_m);
    check("vccint", vccint_p, vi_m);
    check("vccaux", vccaux_p, va_m);
    check("host_rdata", host_rdata_p, rdata_m);
    check("busy", busy_p, 0);
`ifdef XADC_SCHED_OVERTEMP_EN
    check("overtemp", overtemp_p, ot_m);
`endif
  endtask

  task automatic poll_run(input int lat, input logic [15:0] data);
    poll_expect(lat, data);
    eoc_pulse();
    wait_idle();
    check_state();
  endtask

  task automatic host_run(input logic we, input logic [6:0] addr, input logic [15:0] wdata,
                          input int lat, input logic [15:0] data);
    host_expect(we, addr, wdata, lat, data, 1'b1);
    @(negedge clk210_p);
    host_drive(we, addr, wdata, ack_lat(lat));
    wait_idle();
    check_state();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {drp_daddr_p, drp_den_p, drp_dwe_p, drp_di_p, host_ack_p, host_err_p,
                          upd_p, timeout_cnt_p, busy_p}, 0);
    check({tag, "_data"}, {host_rdata_p, temp_p, vccint_p, vccaux_p}, 0);
`ifdef XADC_SCHED_OVERTEMP_EN
    check({tag, "_overtemp"}, overtemp_p, 0);
`endif
  endtask

  // DRP responder and issue monitor
  initial begin : responder
    int          cd;
    logic [15:0] cd_data;
    logic        prev_den;
    iss_t        e;
    rsp_t        r;
    cd = 0; cd_data = 16'd0; prev_den = 1'b0;
    forever begin
      @(negedge clk210_p);
      drp_drdy_p = 1'b0;
      drp_do_p   = 16'($urandom);
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          drp_drdy_p = 1'b1;
          drp_do_p   = cd_data;
        end
      end
      if (drp_dwe_p) check("dwe_only_with_den", drp_den_p, 1);
      if (drp_den_p) begin
        check("den_single_cycle", prev_den, 0);
        last_den_cyc = cyc;
        if (exp_iss.size() == 0) begin
          check("unexpected_den", drp_den_p, 0);
        end else begin
          e = exp_iss.pop_front();
          check("daddr", drp_daddr_p, e.addr);
          check("dwe", drp_dwe_p, e.we);
          if (e.chk_di) check("di", drp_di_p, e.di);
        end
        if (rsp_q.size() > 0) begin
          r = rsp_q.pop_front();
          if (r.lat > 0) begin
            cd = r.lat;
            cd_data = r.data;
          end
        end
      end
      prev_den = drp_den_p;
    end
  end

  // Completion and status-update monitor
  initial begin : monitor
    hst_t h;
    upd_t u;
    forever begin
      @(negedge clk210_p);
      if (reset_n_p) begin
        if (host_ack_p) begin
          if (exp_hst.size() == 0) begin
            check("unexpected_ack", host_ack_p, 0);
          end else begin
            h = exp_hst.pop_front();
            check("ack_err", host_err_p, h.err);
            check("ack_rdata", host_rdata_p, h.rdata);
          end
        end else if (host_err_p) begin
          check("err_without_ack", host_err_p, 0);
        end
        if (upd_p) begin
          if (exp_upd.size() == 0) begin
            check("unexpected_upd", upd_p, 0);
          end else begin
            u = exp_upd.pop_front();
            check("upd_temp", temp_p, u.t);
            check("upd_vccint", vccint_p, u.vi);
            check("upd_vccaux", vccaux_p, u.va);
`ifdef XADC_SCHED_OVERTEMP_EN
            check("upd_overtemp", overtemp_p, u.ot);
`endif
          end
        end
      end
    end
  end

  initial begin : main
    logic [11:0] ot_codes [3];
    model_reset();
    repeat (3) @(negedge clk210_p);
    check_all_zero("reset");
    reset_n_p = 1'b1;
    repeat (2) @(negedge clk210_p);

    // First temperature poll with a slow response.
    poll_run(5, 16'hB600);

    // Polls walk the slots in order and wrap.
    for (int i = 0; i < 4; i++) poll_run(2, 16'($urandom));

    // Host and EOC in the same cycle, plus extra EOCs while the host transaction runs.
    host_expect(1'b0, 7'h40, 16'd0, 10, 16'h1234, 1'b1);
    poll_expect(3, 16'h5670);
    @(negedge clk210_p);
    fork
      host_drive(1'b0, 7'h40, 16'd0, ack_lat(10));
      begin
        eoc_p = 1'b1;
        @(negedge clk210_p);
        eoc_p = 1'b0;
        repeat (3) begin
          @(negedge clk210_p);
          eoc_p = 1'b1;
          @(negedge clk210_p);
          eoc_p = 1'b0;
        end
      end
    join
    wait_idle();
    check("poll_after_ack", last_den_cyc - last_ack_cyc, 1);
    check_state();

    // Host write.
    host_run(1'b1, 7'h41, 16'h2000, 3, 16'hFFFF);

    // Response on the last wait cycle succeeds. One cycle later is a timeout, and the late drdy is ignored.
    poll_run(TO, 16'h7A50);
    host_run(1'b0, 7'h22, 16'd0, TO + 1, 16'hBEEF);

    // Timeouts with no response at all.
    host_run(1'b0, 7'h33, 16'd0, 0, 16'd0);
    poll_run(0, 16'h0000);
    poll_run(0, 16'h0000);
    poll_run(1, 16'hC3A0);

    // Randomised mix of polls, host reads and host writes.
    for (int i = 0; i < 60; i++) begin
      int kind, lat;
      kind = $urandom_range(0, 2);
      lat  = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 8);
      if (kind == 0) poll_run(lat, 16'($urandom));
      else host_run(kind == 2, 7'($urandom), 16'($urandom), lat, 16'($urandom));
    end

    // Drive the timeout counter past saturation.
    while (n_timeouts < 300) poll_run(0, 16'($urandom));

    // Reset in the middle of a wait. No ack is produced, and the later drdy is ignored.
    host_expect(1'b0, 7'h10, 16'd0, 20, 16'hDEAD, 1'b0);
    @(negedge clk210_p);
    host_we_p = 1'b0; host_addr_p = 7'h10; host_req_p = 1'b1;
    repeat (6) @(negedge clk210_p);
    host_req_p = 1'b0;
    #2;
    reset_n_p = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    repeat (2) @(negedge clk210_p);
    reset_n_p = 1'b1;
    repeat (25) @(negedge clk210_p);
    check_state();

    // Temperature hysteresis sequence. Fillers bring the slot back to temperature each time.
    ot_codes[0] = 12'hB60; ot_codes[1] = 12'hB20; ot_codes[2] = 12'hB00;
    for (int i = 0; i < 3; i++) begin
      poll_run(2, {ot_codes[i], 4'h0});
      poll_run(2, 16'($urandom));
      poll_run(2, 16'($urandom));
    end

    repeat (5) @(negedge clk210_p);
    check("iss_queue_drained", exp_iss.size(), 0);
    check("hst_queue_drained", exp_hst.size(), 0);
    check("upd_queue_drained", exp_upd.size(), 0);
    check("rsp_queue_drained", rsp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
